// File: rtl/ld_rs.sv
// ld_rs - reservation station in front of the load unit.
//
// Holds dispatched LD (op 4) / LDR (op 5) operations until both address
// operands are known. It snoops the CDB for outstanding producer tags and
// issues one op at a time into the ld unit. A new op is issued only after
// ld reports completion, so ld never has more than one op outstanding.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   disp_valid/op/pc            dispatch request, opcode and pc
//   disp_rdy0/src0              base operand: value when rdy0=1, else tag [5:0]
//   disp_rdy1/src1              offset operand (ignored for LD)
//   disp_ready                  at least one entry is free
//   cdb_valid/rs_num/data       common data bus broadcast
//   ld_done                     ld unit finished the previously issued op
//   valid                       one-cycle issue pulse to ld
//   rs_num/op/pc/val0/val1      issued op; held between issues
//
// Configuration macro
//   LD_RS_OLDEST_FIRST_EN  defined: the oldest ready entry issues first
//                          (wrap-safe dispatch sequence numbers).
//                          undefined: the lowest-index ready entry issues.

module ld_rs #(
  parameter int         NUM_ENTRIES = 4,
  parameter logic [5:0] RS_BASE     = 6'd8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_valid,
  input  logic [3:0]  disp_op,
  input  logic [15:0] disp_pc,
  input  logic        disp_rdy0,
  input  logic [15:0] disp_src0,
  input  logic        disp_rdy1,
  input  logic [15:0] disp_src1,
  output logic        disp_ready,
  input  logic        cdb_valid,
  input  logic [5:0]  cdb_rs_num,
  input  logic [15:0] cdb_data,
  input  logic        ld_done,
  output logic        valid,
  output logic [5:0]  rs_num,
  output logic [3:0]  op,
  output logic [15:0] pc,
  output logic [15:0] val0,
  output logic [15:0] val1
);

  localparam int         IW     = $clog2(NUM_ENTRIES);
  localparam logic [3:0] OP_LD  = 4'd4;
  localparam logic [3:0] OP_LDR = 4'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  state_e state_r;

  // Entry storage. A non-ready source keeps its producer tag in bits [5:0].
  logic [NUM_ENTRIES-1:0] ent_valid_r;
  logic [NUM_ENTRIES-1:0] ent_rdy0_r;
  logic [NUM_ENTRIES-1:0] ent_rdy1_r;
  logic [3:0]             ent_op_r [NUM_ENTRIES];
  logic [15:0]            ent_pc_r [NUM_ENTRIES];
  logic [15:0]            ent_v0_r [NUM_ENTRIES];
  logic [15:0]            ent_v1_r [NUM_ENTRIES];

  logic                   is_ld_s;
  logic                   op_ok_s;
  logic                   disp_ok_s;
  logic                   byp0_s;
  logic                   byp1_s;
  logic                   src0_rdy_s;
  logic                   src1_rdy_s;
  logic [15:0]            src0_val_s;
  logic [15:0]            src1_val_s;
  logic [IW-1:0]          alloc_idx_s;
  logic [NUM_ENTRIES-1:0] wake0_s;
  logic [NUM_ENTRIES-1:0] wake1_s;
  logic [NUM_ENTRIES-1:0] ready_mask_s;
  logic                   issue_found_s;
  logic [IW-1:0]          issue_idx_s;
  logic                   issue_fire_s;

  // Free-entry indication, derived only from registered entry state.
  assign disp_ready = ~(&ent_valid_r);

  // Dispatch decode, including same-cycle CDB bypass for tagged sources.
  always_comb begin
    is_ld_s    = (disp_op == OP_LD);
    op_ok_s    = is_ld_s || (disp_op == OP_LDR);
    disp_ok_s  = disp_valid && disp_ready && op_ok_s;
    byp0_s     = !disp_rdy0 && cdb_valid && (disp_src0[5:0] == cdb_rs_num);
    byp1_s     = !is_ld_s && !disp_rdy1 && cdb_valid && (disp_src1[5:0] == cdb_rs_num);
    src0_rdy_s = disp_rdy0 || byp0_s;
    src0_val_s = byp0_s ? cdb_data : disp_src0;
    // LD has no offset operand: it is stored as a ready zero.
    src1_rdy_s = is_ld_s || disp_rdy1 || byp1_s;
    src1_val_s = is_ld_s ? 16'h0000 : (byp1_s ? cdb_data : disp_src1);
  end

  // Lowest-index free entry; descending scan so the lowest match wins.
  always_comb begin
    alloc_idx_s = {IW{1'b0}};
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      alloc_idx_s = ent_valid_r[i] ? alloc_idx_s : IW'(i);
    end
  end

  // CDB tag match per stored source.
  always_comb begin
    wake0_s = {NUM_ENTRIES{1'b0}};
    wake1_s = {NUM_ENTRIES{1'b0}};
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      wake0_s[i] = ent_valid_r[i] && !ent_rdy0_r[i] && cdb_valid &&
                   (ent_v0_r[i][5:0] == cdb_rs_num);
      wake1_s[i] = ent_valid_r[i] && !ent_rdy1_r[i] && cdb_valid &&
                   (ent_v1_r[i][5:0] == cdb_rs_num);
    end
  end

  assign ready_mask_s = ent_valid_r & ent_rdy0_r & ent_rdy1_r;
  assign issue_fire_s = (state_r == ST_IDLE) && issue_found_s;

`ifdef LD_RS_OLDEST_FIRST_EN
  localparam int SW = $clog2(NUM_ENTRIES) + 1;

  logic [SW-1:0] disp_seq_r;
  logic [SW-1:0] ent_seq_r [NUM_ENTRIES];

  // Oldest ready entry: age is the modular distance back from the next
  // sequence number, so it stays correct across counter wrap. At most
  // NUM_ENTRIES entries are live and the counter spans 2*NUM_ENTRIES values.
  always_comb begin
    logic [SW-1:0] best_age_v;
    logic [SW-1:0] age_v;
    logic          take_v;
    best_age_v    = {SW{1'b0}};
    age_v         = {SW{1'b0}};
    take_v        = 1'b0;
    issue_found_s = 1'b0;
    issue_idx_s   = {IW{1'b0}};
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      age_v         = disp_seq_r - ent_seq_r[i];
      take_v        = ready_mask_s[i] && (age_v > best_age_v);
      best_age_v    = take_v ? age_v : best_age_v;
      issue_idx_s   = take_v ? IW'(i) : issue_idx_s;
      issue_found_s = issue_found_s || ready_mask_s[i];
    end
  end

  // Dispatch sequence counter, advanced on every accepted dispatch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_seq_r <= {SW{1'b0}};
    end else if (disp_ok_s) begin
      disp_seq_r <= disp_seq_r + SW'(1);
    end
  end

  // Per-entry sequence number captured at allocation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_seq_r[i] <= {SW{1'b0}};
      end
    end else if (disp_ok_s) begin
      ent_seq_r[alloc_idx_s] <= disp_seq_r;
    end
  end
`else
  // Lowest-index ready entry; descending scan so the lowest match wins.
  always_comb begin
    issue_found_s = |ready_mask_s;
    issue_idx_s   = {IW{1'b0}};
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      issue_idx_s = ready_mask_s[i] ? IW'(i) : issue_idx_s;
    end
  end
`endif

  // Entry state: CDB wakeup, release on issue, allocation on dispatch.
  // An issued entry is fully ready and never the allocation target in the
  // same cycle, since allocation only picks entries already free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid_r <= {NUM_ENTRIES{1'b0}};
      ent_rdy0_r  <= {NUM_ENTRIES{1'b0}};
      ent_rdy1_r  <= {NUM_ENTRIES{1'b0}};
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        ent_op_r[i] <= 4'd0;
        ent_pc_r[i] <= 16'h0000;
        ent_v0_r[i] <= 16'h0000;
        ent_v1_r[i] <= 16'h0000;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (wake0_s[i]) begin
          ent_rdy0_r[i] <= 1'b1;
          ent_v0_r[i]   <= cdb_data;
        end
        if (wake1_s[i]) begin
          ent_rdy1_r[i] <= 1'b1;
          ent_v1_r[i]   <= cdb_data;
        end
        if (issue_fire_s && (issue_idx_s == IW'(i))) begin
          ent_valid_r[i] <= 1'b0;
        end
        if (disp_ok_s && (alloc_idx_s == IW'(i))) begin
          ent_valid_r[i] <= 1'b1;
          ent_op_r[i]    <= disp_op;
          ent_pc_r[i]    <= disp_pc;
          ent_rdy0_r[i]  <= src0_rdy_s;
          ent_v0_r[i]    <= src0_val_s;
          ent_rdy1_r[i]  <= src1_rdy_s;
          ent_v1_r[i]    <= src1_val_s;
        end
      end
    end
  end

  // Issue FSM with registered outputs; valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      valid   <= 1'b0;
      rs_num  <= 6'd0;
      op      <= 4'd0;
      pc      <= 16'h0000;
      val0    <= 16'h0000;
      val1    <= 16'h0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (issue_found_s) begin
            valid   <= 1'b1;
            rs_num  <= RS_BASE + 6'(issue_idx_s);
            op      <= ent_op_r[issue_idx_s];
            pc      <= ent_pc_r[issue_idx_s];
            val0    <= ent_v0_r[issue_idx_s];
            val1    <= ent_v1_r[issue_idx_s];
            state_r <= ST_WAIT;
          end else begin
            valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          valid <= 1'b0;
          if (ld_done) begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          valid   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ld_rs.sv
// tb_ld_rs - directed scoreboard bench for ld_rs.
// Stimulus pushes the expected issued op {rs_num, op, pc, val0, val1} into a
// queue; a monitor pops and compares on every valid pulse.
`timescale 1ns/1ps

module tb_ld_rs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_valid = 1'b0;
  logic [3:0]  disp_op = 4'd0;
  logic [15:0] disp_pc = 16'h0000;
  logic        disp_rdy0 = 1'b0;
  logic [15:0] disp_src0 = 16'h0000;
  logic        disp_rdy1 = 1'b0;
  logic [15:0] disp_src1 = 16'h0000;
  logic        disp_ready;
  logic        cdb_valid = 1'b0;
  logic [5:0]  cdb_rs_num = 6'd0;
  logic [15:0] cdb_data = 16'h0000;
  logic        ld_done = 1'b0;
  logic        valid;
  logic [5:0]  rs_num;
  logic [3:0]  op;
  logic [15:0] pc;
  logic [15:0] val0;
  logic [15:0] val1;

  ld_rs #(.NUM_ENTRIES(4), .RS_BASE(6'd8)) dut (
    .clk(clk), .rst_n(rst_n),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_pc(disp_pc),
    .disp_rdy0(disp_rdy0), .disp_src0(disp_src0),
    .disp_rdy1(disp_rdy1), .disp_src1(disp_src1),
    .disp_ready(disp_ready),
    .cdb_valid(cdb_valid), .cdb_rs_num(cdb_rs_num), .cdb_data(cdb_data),
    .ld_done(ld_done),
    .valid(valid), .rs_num(rs_num), .op(op), .pc(pc), .val0(val0), .val1(val1)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [57:0] exp_q[$];
  logic [57:0] mon_e;
  logic        prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every issue pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      check("valid_single_cycle", {63'd0, prev_valid}, 64'd0);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue actual rs_num=%0d pc=0x%0h required=no issue", rs_num, pc);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_rs_num", {58'd0, rs_num}, {58'd0, mon_e[57:52]});
        check("issue_op",     {60'd0, op},     {60'd0, mon_e[51:48]});
        check("issue_pc",     {48'd0, pc},     {48'd0, mon_e[47:32]});
        check("issue_val0",   {48'd0, val0},   {48'd0, mon_e[31:16]});
        check("issue_val1",   {48'd0, val1},   {48'd0, mon_e[15:0]});
      end
    end
    prev_valid = valid & rst_n;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_disp(input logic [3:0] o, input logic [15:0] p,
                            input logic r0, input logic [15:0] s0,
                            input logic r1, input logic [15:0] s1);
    disp_valid = 1'b1; disp_op = o; disp_pc = p;
    disp_rdy0 = r0; disp_src0 = s0; disp_rdy1 = r1; disp_src1 = s1;
    cyc(1);
    disp_valid = 1'b0;
  endtask

  task automatic bcast(input logic [5:0] t, input logic [15:0] d);
    cdb_valid = 1'b1; cdb_rs_num = t; cdb_data = d;
    cyc(1);
    cdb_valid = 1'b0;
  endtask

  task automatic ld_ack();
    ld_done = 1'b1;
    cyc(1);
    ld_done = 1'b0;
  endtask

  // Bounded wait for the next issue pulse; a timeout is a failed check.
  task automatic wait_issue(input string name, input int bound);
    int n;
    n = 0;
    @(negedge clk);
    while (!valid && n < bound) begin
      n++;
      @(negedge clk);
    end
    check(name, {63'd0, valid}, 64'd1);
  endtask

  task automatic ack_and_expect(input string name);
    ld_ack();
    wait_issue(name, 6);
  endtask

  // Watchdog in case something unbounded slips through.
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int vcnt;
    // Reset state
    cyc(2);
    @(negedge clk);
    check("reset_outputs", {6'd0, valid, rs_num, op, pc, val0, val1}, 64'd0);
    check("reset_disp_ready", {63'd0, disp_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc(1);

    // 1: ready LD issues one cycle after dispatch, then waits for ld_done
    exp_q.push_back({6'd8, 4'd4, 16'h1000, 16'h0100, 16'h0000});
    drive_disp(4'd4, 16'h1000, 1'b1, 16'h0100, 1'b0, 16'hBEEF);
    @(negedge clk); check("t1_no_issue_dispatch_cycle", {63'd0, valid}, 64'd0);
    @(negedge clk); check("t1_issue_latency", {63'd0, valid}, 64'd1);
    exp_q.push_back({6'd8, 4'd4, 16'h1004, 16'h0104, 16'h0000});
    drive_disp(4'd4, 16'h1004, 1'b1, 16'h0104, 1'b0, 16'h0000);
    vcnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (valid) vcnt++;
    end
    check("t1_hold_until_ld_done", 64'(vcnt), 64'd0);
    ld_ack();
    @(negedge clk); check("t1_no_issue_on_done_edge", {63'd0, valid}, 64'd0);
    @(negedge clk); check("t1_issue_after_done", {63'd0, valid}, 64'd1);
    ld_ack();

    // 2: LDR waits on tag 3, woken two cycles after dispatch
    exp_q.push_back({6'd8, 4'd5, 16'h2000, 16'h0200, 16'h0004});
    drive_disp(4'd5, 16'h2000, 1'b0, 16'h0003, 1'b1, 16'h0004);
    cyc(1);
    bcast(6'd3, 16'h0200);
    @(negedge clk); check("t2_not_before_wakeup", {63'd0, valid}, 64'd0);
    @(negedge clk); check("t2_issue_after_wakeup", {63'd0, valid}, 64'd1);
    ld_ack();

    // 3: dispatch bypass from same-cycle CDB broadcast
    exp_q.push_back({6'd8, 4'd4, 16'h3000, 16'h0055, 16'h0000});
    cdb_valid = 1'b1; cdb_rs_num = 6'd7; cdb_data = 16'h0055;
    drive_disp(4'd4, 16'h3000, 1'b0, 16'h0007, 1'b0, 16'h0000);
    cdb_valid = 1'b0;
    wait_issue("t3_bypass_issue", 4);
    ld_ack();

    // 4: fill, drop the fifth, wake one, then drain
    for (int k = 0; k < 4; k++) begin
      drive_disp(4'd4, 16'h4000 + 16'(k), 1'b0, 16'h0011 + 16'(k), 1'b0, 16'h0000);
    end
    @(negedge clk); check("t4_full_disp_ready", {63'd0, disp_ready}, 64'd0);
    drive_disp(4'd4, 16'h4004, 1'b0, 16'h0015, 1'b0, 16'h0000);
    exp_q.push_back({6'd9, 4'd4, 16'h4001, 16'h0A12, 16'h0000});
    bcast(6'h12, 16'h0A12);
    @(negedge clk); check("t4_still_full_before_issue", {63'd0, disp_ready}, 64'd0);
    @(negedge clk);
    check("t4_issue_after_wake", {63'd0, valid}, 64'd1);
    check("t4_ready_after_issue", {63'd0, disp_ready}, 64'd1);
    exp_q.push_back({6'd8,  4'd4, 16'h4000, 16'h0A11, 16'h0000});
    exp_q.push_back({6'd10, 4'd4, 16'h4002, 16'h0A13, 16'h0000});
    exp_q.push_back({6'd11, 4'd4, 16'h4003, 16'h0A14, 16'h0000});
    bcast(6'h11, 16'h0A11);
    bcast(6'h13, 16'h0A13);
    bcast(6'h14, 16'h0A14);
    ack_and_expect("t4_drain_0");
    ack_and_expect("t4_drain_2");
    ack_and_expect("t4_drain_3");
    ld_ack();
    // the dropped fifth op must never appear
    bcast(6'h15, 16'h0A15);
    cyc(6);

    // 5: entry 2 dispatched before entry 0, both woken together
    drive_disp(4'd4, 16'h5000, 1'b0, 16'h0021, 1'b0, 16'h0000);
    drive_disp(4'd4, 16'h5001, 1'b0, 16'h0022, 1'b0, 16'h0000);
    drive_disp(4'd4, 16'h5002, 1'b0, 16'h0025, 1'b0, 16'h0000);
    exp_q.push_back({6'd8, 4'd4, 16'h5000, 16'h0A21, 16'h0000});
    bcast(6'h21, 16'h0A21);
    wait_issue("t5_first_issue", 4);
    drive_disp(4'd4, 16'h5003, 1'b0, 16'h0025, 1'b0, 16'h0000);
`ifdef LD_RS_OLDEST_FIRST_EN
    exp_q.push_back({6'd10, 4'd4, 16'h5002, 16'h0A25, 16'h0000});
    exp_q.push_back({6'd8,  4'd4, 16'h5003, 16'h0A25, 16'h0000});
`else
    exp_q.push_back({6'd8,  4'd4, 16'h5003, 16'h0A25, 16'h0000});
    exp_q.push_back({6'd10, 4'd4, 16'h5002, 16'h0A25, 16'h0000});
`endif
    bcast(6'h25, 16'h0A25);
    ack_and_expect("t5_order_a");
    ack_and_expect("t5_order_b");
    exp_q.push_back({6'd9, 4'd4, 16'h5001, 16'h0A22, 16'h0000});
    bcast(6'h22, 16'h0A22);
    ack_and_expect("t5_last");
    ld_ack();

    // 6: reset during WAIT drops everything
    drive_disp(4'd4, 16'h6000, 1'b0, 16'h0030, 1'b0, 16'h0000);
    exp_q.push_back({6'd9, 4'd4, 16'h6001, 16'h0601, 16'h0000});
    drive_disp(4'd4, 16'h6001, 1'b1, 16'h0601, 1'b0, 16'h0000);
    wait_issue("t6_issue_before_reset", 4);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_reset_outputs", {6'd0, valid, rs_num, op, pc, val0, val1}, 64'd0);
    check("t6_async_reset_disp_ready", {63'd0, disp_ready}, 64'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ld_ack();
    bcast(6'h30, 16'h0A30);
    drive_disp(4'd3, 16'h6100, 1'b1, 16'h0611, 1'b1, 16'h0000);
    cyc(4);
    @(negedge clk); check("t6_bad_op_not_allocated", {63'd0, disp_ready}, 64'd1);
    exp_q.push_back({6'd8, 4'd5, 16'h6200, 16'h0622, 16'h0007});
    drive_disp(4'd5, 16'h6200, 1'b1, 16'h0622, 1'b1, 16'h0007);
    wait_issue("t6_post_reset_issue", 4);
    ld_ack();
    cyc(3);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
